// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-to-hazard-unit signal bundle
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] i_id_rs1_addr;
    logic [REG_AW-1:0] i_id_rs2_addr;
    logic              i_id_rs1_use;
    logic              i_id_rs2_use;
    logic [REG_AW-1:0] i_ex_rs1_addr;
    logic [REG_AW-1:0] i_ex_rs2_addr;
    logic [REG_AW-1:0] i_ex_rd_addr;
    logic              i_ex_rd_wren;
    logic              i_ex_mem_rden;
    logic [REG_AW-1:0] i_mem_rd_addr;
    logic              i_mem_rd_wren;
    logic [REG_AW-1:0] i_wb_rd_addr;
    logic              i_wb_rd_wren;
    logic              i_ex_redirect;
    logic              i_ex_busy;
    logic              i_mem_wait;
    logic              o_pc_enable;
    logic              o_if_id_enable;
    logic              o_if_id_flush;
    logic              o_id_ex_flush;
    logic              o_ex_mem_enable;
    logic              o_mem_wb_enable;
    logic [1:0]        o_fw_a;
    logic [1:0]        o_fw_b;
    logic [1:0]        o_state;
    logic [CNT_W-1:0]  o_stall_cnt;
    logic [CNT_W-1:0]  o_flush_cnt;

    modport master (
        output i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_use, i_id_rs2_use,
               i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr, i_ex_rd_wren, i_ex_mem_rden,
               i_mem_rd_addr, i_mem_rd_wren, i_wb_rd_addr, i_wb_rd_wren,
               i_ex_redirect, i_ex_busy, i_mem_wait,
        input  o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_flush,
               o_ex_mem_enable, o_mem_wb_enable, o_fw_a, o_fw_b, o_state,
               o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_use, i_id_rs2_use,
               i_ex_rs1_addr, i_ex_rs2_addr, i_ex_rd_addr, i_ex_rd_wren, i_ex_mem_rden,
               i_mem_rd_addr, i_mem_rd_wren, i_wb_rd_addr, i_wb_rd_wren,
               i_ex_redirect, i_ex_busy, i_mem_wait,
        output o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_flush,
               o_ex_mem_enable, o_mem_wb_enable, o_fw_a, o_fw_b, o_state,
               o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline hazard, forwarding and stall control
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int FW_EN     = 1,
    parameter int RF_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input logic              i_clk,
    input logic              i_rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LD_STALL = 2'b01,
        ST_BUSY     = 2'b10,
        ST_FREEZE   = 2'b11
    } state_e;

    state_e           state_q, state_d, mode;
    logic [1:0]       ld_cnt_q, ld_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic pc_en, if_id_en, if_id_fl, id_ex_fl, ex_mem_en, mem_wb_en;
    logic id_hit_ex, id_hit_mem, id_hit_wb, ldh, raw;
    logic [1:0] fw_a, fw_b;

    function automatic logic reg_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    function automatic logic [1:0] fw_sel(input logic [REG_AW-1:0] rs,
                                          input logic mem_wr, input logic [REG_AW-1:0] mem_rd,
                                          input logic wb_wr, input logic [REG_AW-1:0] wb_rd);
        if (mem_wr && reg_hit(mem_rd, rs)) return 2'b01;
        if (wb_wr && reg_hit(wb_rd, rs))   return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic id_hit(input logic [REG_AW-1:0] rd,
                                    input logic u1, input logic [REG_AW-1:0] rs1,
                                    input logic u2, input logic [REG_AW-1:0] rs2);
        return (u1 && reg_hit(rd, rs1)) || (u2 && reg_hit(rd, rs2));
    endfunction

    assign id_hit_ex  = id_hit(hz.i_ex_rd_addr, hz.i_id_rs1_use, hz.i_id_rs1_addr,
                               hz.i_id_rs2_use, hz.i_id_rs2_addr);
    assign id_hit_mem = id_hit(hz.i_mem_rd_addr, hz.i_id_rs1_use, hz.i_id_rs1_addr,
                               hz.i_id_rs2_use, hz.i_id_rs2_addr);
    assign id_hit_wb  = id_hit(hz.i_wb_rd_addr, hz.i_id_rs1_use, hz.i_id_rs1_addr,
                               hz.i_id_rs2_use, hz.i_id_rs2_addr);

    assign ldh = hz.i_ex_mem_rden && hz.i_ex_rd_wren && id_hit_ex;
    // Without forwarding every in-flight producer blocks ID; WB only when the RF cannot write through.
    assign raw = (FW_EN == 0) &&
                 ((hz.i_ex_rd_wren && id_hit_ex) || (hz.i_mem_rd_wren && id_hit_mem) ||
                  ((RF_BYPASS == 0) && hz.i_wb_rd_wren && id_hit_wb));

    always_comb begin
        fw_a = 2'b00;
        fw_b = 2'b00;
        if (FW_EN != 0) begin
            fw_a = fw_sel(hz.i_ex_rs1_addr, hz.i_mem_rd_wren, hz.i_mem_rd_addr,
                          hz.i_wb_rd_wren, hz.i_wb_rd_addr);
            fw_b = fw_sel(hz.i_ex_rs2_addr, hz.i_mem_rd_wren, hz.i_mem_rd_addr,
                          hz.i_wb_rd_wren, hz.i_wb_rd_addr);
        end
    end

    always_comb begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        if_id_fl  = 1'b0;
        id_ex_fl  = 1'b0;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        mode      = ST_RUN;
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        if (hz.i_ex_redirect) begin
            if_id_fl = 1'b1;
            id_ex_fl = 1'b1;
            state_d  = ST_RUN;
            ld_cnt_d = 2'd0;
        end else if (hz.i_mem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            mode      = ST_FREEZE;
        end else if (hz.i_ex_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            ex_mem_en = 1'b0;
            mode      = ST_BUSY;
        end else if (state_q == ST_LD_STALL || ldh || raw) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_fl = 1'b1;
            mode     = ST_LD_STALL;
            // The detect cycle is the first bubble, so LD_STALL covers the remaining LOAD_LAT-1.
            if (state_q == ST_LD_STALL) begin
                if (ld_cnt_q <= 2'd1) begin
                    state_d  = ST_RUN;
                    ld_cnt_d = 2'd0;
                end else begin
                    ld_cnt_d = ld_cnt_q - 2'd1;
                end
            end else if (ldh && LOAD_LAT > 1) begin
                state_d  = ST_LD_STALL;
                ld_cnt_d = 2'(LOAD_LAT - 1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            ld_cnt_q    <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            if (!pc_en && !hz.i_ex_redirect && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (hz.i_ex_redirect && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hz.o_pc_enable     = i_rst | pc_en;
    assign hz.o_if_id_enable  = i_rst | if_id_en;
    assign hz.o_if_id_flush   = ~i_rst & if_id_fl;
    assign hz.o_id_ex_flush   = ~i_rst & id_ex_fl;
    assign hz.o_ex_mem_enable = i_rst | ex_mem_en;
    assign hz.o_mem_wb_enable = i_rst | mem_wb_en;
    assign hz.o_fw_a          = i_rst ? 2'b00 : fw_a;
    assign hz.o_fw_b          = i_rst ? 2'b00 : fw_b;
    assign hz.o_state         = mode;
    assign hz.o_stall_cnt     = stall_cnt_q;
    assign hz.o_flush_cnt     = flush_cnt_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard/control unit for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Replaces the separate load-use detector and EX forwarding selector with one block. It adds:
  - branch/jump redirect flush;
  - multi-cycle load-use stall;
  - multi-cycle EX unit stall;
  - memory-wait freeze;
  - a stall-on-RAW mode for forwarding-less builds;
  - saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 1, load-use bubbles inserted (1..3).
- FW_EN, 1, 1 = EX forwarding from EX/MEM and MEM/WB; 0 = stall on any RAW.
- RF_BYPASS, 1, 1 = register file write-through (WB-to-ID needs no stall).
- CNT_W, 16, width of the performance counters.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous reset, active-high
- i_id_rs1_addr  in  REG_AW  ID source 1
- i_id_rs2_addr  in  REG_AW  ID source 2
- i_id_rs1_use  in  1  ID instruction reads rs1
- i_id_rs2_use  in  1  ID instruction reads rs2
- i_ex_rs1_addr  in  REG_AW  EX source 1
- i_ex_rs2_addr  in  REG_AW  EX source 2
- i_ex_rd_addr  in  REG_AW  EX destination
- i_ex_rd_wren  in  1  EX writes rd
- i_ex_mem_rden  in  1  EX is a load
- i_mem_rd_addr  in  REG_AW  MEM destination
- i_mem_rd_wren  in  1  MEM writes rd
- i_wb_rd_addr  in  REG_AW  WB destination
- i_wb_rd_wren  in  1  WB writes rd
- i_ex_redirect  in  1  branch taken / jump resolved in EX
- i_ex_busy  in  1  multi-cycle EX unit not done
- i_mem_wait  in  1  data memory not ready
- o_pc_enable  out  1  PC update enable
- o_if_id_enable  out  1  IF/ID load enable
- o_if_id_flush  out  1  IF/ID clear to NOP
- o_id_ex_flush  out  1  ID/EX clear to bubble
- o_ex_mem_enable  out  1  EX/MEM load enable
- o_mem_wb_enable  out  1  MEM/WB load enable
- o_fw_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- o_fw_b  out  2  EX operand B select, same encoding
- o_state  out  2  00 RUN, 01 LD_STALL, 10 BUSY, 11 FREEZE
- o_stall_cnt  out  CNT_W  cycles with o_pc_enable=0 and no redirect
- o_flush_cnt  out  CNT_W  redirect events

Behaviour:
- Reset, synchronous: state=RUN, ld_cnt=0, both counters=0.
  - Outputs combinational on state and inputs; while i_rst=1 the outputs are forced to: all enables 1, flushes 0, fw 00.
- Register x0 (addr 0) never matches for forwarding or hazards.
- Forwarding (FW_EN=1), per operand:
  - 01 if i_mem_rd_wren, mem_rd≠0 and mem_rd==ex_rs;
  - else 10 if the same holds for WB;
  - else 00.
  - MEM has priority over WB.
  - FW_EN=0: o_fw_a/b always 00.
- Load-use hazard (ldh): i_ex_mem_rden & i_ex_rd_wren & ex_rd≠0 & ex_rd matches a used ID source.
- RAW hazard (FW_EN=0 only): a used ID source matches a writing EX or MEM rd, or a writing WB rd when RF_BYPASS=0.
- Priority, highest first: i_ex_redirect > i_mem_wait > i_ex_busy > ldh/RAW/LD_STALL > RUN.
- Redirect:
  - o_if_id_flush=1, o_id_ex_flush=1, PC enabled (loads the target).
  - Next state RUN, ld_cnt cleared, o_flush_cnt+1.
  - Aborts any LD_STALL in progress.
- i_mem_wait (FREEZE):
  - all enables 0, flushes 0;
  - state and ld_cnt held internally; o_state=11;
  - returns to the held state when i_mem_wait drops.
- i_ex_busy (BUSY):
  - pc, IF/ID and EX/MEM enables 0;
  - o_mem_wb_enable=1;
  - MEM/WB drains a bubble: EX/MEM held, the MEM stage output is marked invalid by the pipeline.
  - o_id_ex_flush=0 (the EX instruction is held).
- Load-use:
  - In RUN with ldh: go to LD_STALL, ld_cnt=LOAD_LAT-1.
  - In the detect cycle and every LD_STALL cycle: pc=0, if_id=0, o_id_ex_flush=1; later stages advance.
  - LD_STALL: while ld_cnt≠0, decrement; when ld_cnt==0, go to RUN.
  - Total bubbles = LOAD_LAT.
- RAW (FW_EN=0): same stall signalling as load-use, re-evaluated each cycle; no counter.
- o_stall_cnt increments on every cycle with o_pc_enable=0 and i_ex_redirect=0.
- Both counters saturate at 2^CNT_W-1.

Test Plan:
- Forwarding, FW_EN=1:
  - EX rs1=5; MEM rd=5 wren; WB rd=5 wren -> o_fw_a=01.
  - Drop MEM wren -> 10.
  - rs1=0 with MEM rd=0 -> 00.
- Load-use, LOAD_LAT=2:
  - Load x3 in EX, ID uses rs2=3 -> 2 cycles of pc=0, if_id=0, id_ex_flush=1, o_state=01; then RUN.
  - o_stall_cnt=2.
- Redirect during LD_STALL, LOAD_LAT=3:
  - Assert i_ex_redirect in the 2nd stall cycle -> both flushes=1, pc=1.
  - Next cycle o_state=00; o_flush_cnt=1.
- Freeze:
  - i_mem_wait for 3 cycles mid LD_STALL -> all enables 0, o_state=11.
  - Afterwards the remaining stall cycles complete; total stall count = LOAD_LAT+3.
- Busy and reset:
  - i_ex_busy 4 cycles -> pc/if_id/ex_mem=0, mem_wb=1, o_state=10.
  - Assert i_rst mid-sequence -> next cycle state RUN, counters 0.
- FW_EN=0, RF_BYPASS=0:
  - WB rd=7 wren, ID rs1=7 -> stall 1 cycle.
  - With RF_BYPASS=1 -> no stall.
- Saturation:
  - CNT_W=4, 20 stall cycles -> o_stall_cnt=15.
